// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles the requester handshake and the uart_tx load/busy signals of the
// uart_tx_arbiter.
//   slave  : the arbiter side (consumes requests and tx_busy, drives the
//            ready pulses, the uart_tx load and the grant status).
//   master : the environment side (requesters plus uart_tx).
//
// Signals
//   i_req_valid  [NumReq]    requester k offers a byte
//   i_req_data   [8*NumReq]  requester k's byte on bits [8k+7:8k]
//   i_req_last   [NumReq]    offered byte ends its packet
//   o_req_ready  [NumReq]    one-hot accept pulse
//   o_tx_enable              one-cycle load strobe to uart_tx
//   o_tx_data    [8]         byte presented to uart_tx
//   i_tx_busy                busy flag from uart_tx
//   o_grant_valid            a requester owns the transmitter
//   o_grant_idx  [IdxW]      index of the owner
//   o_busy_err               pulse when tx_busy never rose after a load
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NumReq = 4,
    parameter int IdxW   = 2
);
    logic [NumReq-1:0]   i_req_valid;
    logic [8*NumReq-1:0] i_req_data;
    logic [NumReq-1:0]   i_req_last;
    logic [NumReq-1:0]   o_req_ready;
    logic                o_tx_enable;
    logic [7:0]          o_tx_data;
    logic                i_tx_busy;
    logic                o_grant_valid;
    logic [IdxW-1:0]     o_grant_idx;
    logic                o_busy_err;

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_busy,
        output o_req_ready, o_tx_enable, o_tx_data,
               o_grant_valid, o_grant_idx, o_busy_err
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_busy,
        input  o_req_ready, o_tx_enable, o_tx_data,
               o_grant_valid, o_grant_idx, o_busy_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter sharing one uart_tx between NumReq byte-stream
// requesters. One byte is accepted at a time, loaded into uart_tx with a
// one-cycle strobe, and the arbiter then follows tx_busy until the frame is
// done. Packets (bytes up to one marked last) stay contiguous on the wire.
//
// Ports
//   i_clk    single clock
//   i_rst_n  synchronous active-low reset
//   bus      uart_tx_arbiter_if.slave (requester handshake, uart_tx load/busy,
//            grant status, busy-timeout error)
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NumReq      = 4,
    parameter int IdxW        = 2,
    parameter int BusyTimeout = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    uart_tx_arbiter_if.slave     bus
);
    localparam int CntW = $clog2(BusyTimeout) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] owner_q;
    logic            lock_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      tx_data_q;

    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic            accept;
    logic [7:0]      acc_data;
    logic            acc_last;
    logic            tx_enable;
    logic            busy_err;

    // Successor of a requester index, wrapping at NumReq-1 (NumReq need not
    // be a power of two).
    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        if (int'(i) >= NumReq - 1) return '0;
        return i + IdxW'(1);
    endfunction

    // Round-robin scan starting at ptr. While a packet is open only the
    // owner is eligible, so the scan can only ever hit the owner.
    // NOTE: every signal written here gets a default before any branch;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        int k;
        logic [IdxW-1:0] cand;
        win_found = 1'b0;
        win_idx   = ptr_q;
        k         = 0;
        cand      = '0;
        for (int off = 0; off < NumReq; off++) begin
            k = int'(ptr_q) + off;
            if (k >= NumReq) k = k - NumReq;
            cand = IdxW'(k);
            if (!win_found && bus.i_req_valid[cand] && (!lock_q || cand == owner_q)) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Accept is gated by reset so no handshake is seen while in reset.
    assign accept   = (state_q == ST_IDLE) && win_found && !bus.i_tx_busy && i_rst_n;
    assign acc_data = bus.i_req_data[{win_idx, 3'b000} +: 8];
    assign acc_last = bus.i_req_last[win_idx];

    always_comb begin
        bus.o_req_ready = '0;
        if (accept) bus.o_req_ready[win_idx] = 1'b1;
    end

    // Next-state logic and strobes.
    always_comb begin
        state_d   = state_q;
        tx_enable = 1'b0;
        busy_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_enable = 1'b1;
                state_d   = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (bus.i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CntW'(BusyTimeout - 1)) begin
                    // This increment is the one that reaches BusyTimeout.
                    busy_err = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.i_tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            tx_data_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data_q <= acc_data;
                        owner_q   <= win_idx;
                        lock_q    <= ~acc_last;
                        if (acc_last) ptr_q <= next_idx(win_idx);
                    end
                end
                ST_LOAD: begin
                    cnt_q <= '0;
                end
                ST_WAIT_START: begin
                    if (!bus.i_tx_busy) begin
                        cnt_q <= cnt_q + CntW'(1);
                        // A dead transmitter also releases any open packet.
                        if (busy_err) begin
                            lock_q <= 1'b0;
                            ptr_q  <= next_idx(owner_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_tx_enable   = tx_enable;
    assign bus.o_busy_err    = busy_err;
    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_grant_valid = (state_q != ST_IDLE) | lock_q;
    assign bus.o_grant_idx   = owner_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with four requesters. Each requester is a
// small byte FIFO filled by the test tasks; a uart_tx stub raises busy one
// cycle after the load strobe for FRAME cycles and logs every loaded byte.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int NR    = 4;
    localparam int FRAME = 8;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    uart_tx_arbiter_if #(.NumReq(NR), .IdxW(2)) bus ();

    uart_tx_arbiter #(.NumReq(NR), .IdxW(2), .BusyTimeout(16)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Requester FIFOs: {last, data}. wr_cnt written by tasks, rd_cnt by the
    // handshake process.
    logic [8:0] mem [NR][64];
    logic [5:0] wr_cnt [NR] = '{default: '0};
    logic [5:0] rd_cnt [NR] = '{default: '0};
    logic [NR-1:0] en;

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            bus.i_req_valid[k]       = en[k] && (rd_cnt[k] != wr_cnt[k]);
            bus.i_req_data[8*k +: 8] = mem[k][rd_cnt[k]][7:0];
            bus.i_req_last[k]        = mem[k][rd_cnt[k]][8];
        end
    end

    // uart_tx stub: 0 normal, 1 busy stuck low, 2 busy forced high.
    int busy_mode = 0;
    int busy_cnt  = 0;
    int cyc       = 0;
    assign bus.i_tx_busy = (busy_mode == 2) || (busy_mode == 0 && busy_cnt != 0);

    logic [7:0] sent_q[$];
    int         en_cyc_q[$];

    bit mon_on  = 1'b0;
    bit prev_hs = 1'b0;
    int mon_bad = 0;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NR; k++)
            if (bus.i_req_valid[k] && bus.o_req_ready[k]) rd_cnt[k] <= rd_cnt[k] + 6'd1;
        if (!i_rst_n) begin
            busy_cnt <= 0;
        end else if (bus.o_tx_enable) begin
            busy_cnt <= FRAME;
            sent_q.push_back(bus.o_tx_data);
            en_cyc_q.push_back(cyc);
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        // Protocol monitor: enable exactly one cycle after each accept,
        // ready one-hot and never while busy.
        if (mon_on && i_rst_n) begin
            if (bus.o_tx_enable !== prev_hs) mon_bad <= mon_bad + 1;
            if ($countones(bus.o_req_ready) > 1) mon_bad <= mon_bad + 1;
            if (bus.o_req_ready != 0 && bus.i_tx_busy) mon_bad <= mon_bad + 1;
        end
        prev_hs <= i_rst_n && ((bus.i_req_valid & bus.o_req_ready) != 0);
    end

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        mem[k][wr_cnt[k]] = {l, d};
        wr_cnt[k] = wr_cnt[k] + 6'd1;
    endtask

    task automatic apply_reset();
        en = '0;
        for (int k = 0; k < NR; k++) wr_cnt[k] = rd_cnt[k];
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        sent_q.delete();
        en_cyc_q.delete();
    endtask

    // Wait until n bytes were loaded and the block is back to idle.
    task automatic wait_sent(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (sent_q.size() >= n && !bus.o_grant_valid && !bus.i_tx_busy && !bus.o_tx_enable) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_count(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (sent_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        en = '0;
        busy_mode = 0;
        i_rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus.o_req_ready, bus.o_tx_enable, bus.o_tx_data, bus.o_grant_valid,
             bus.o_grant_idx, bus.o_busy_err} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b en=%b data=%h gv=%b gi=%0d err=%b, expected all 0",
                     bus.o_req_ready, bus.o_tx_enable, bus.o_tx_data, bus.o_grant_valid,
                     bus.o_grant_idx, bus.o_busy_err);
        end
        i_rst_n = 1'b1;
        mon_on = 1'b1;
        step();
        checks++;
        if (bus.o_grant_valid !== 1'b0 || bus.o_tx_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got gv=%b en=%b, expected 0 0", bus.o_grant_valid, bus.o_tx_enable);
        end
    endtask

    task automatic test_single();
        bit ok;
        step();
        push(2, 8'hA5, 1'b1);
        en = 4'b0100;
        #1;
        checks++;
        if (bus.o_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b, expected 0100", bus.o_req_ready);
        end
        step();
        checks++;
        if (bus.o_tx_enable !== 1'b1 || bus.o_tx_data !== 8'hA5 || bus.o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_load: got en=%b data=%h ready=%b, expected 1 a5 0000",
                     bus.o_tx_enable, bus.o_tx_data, bus.o_req_ready);
        end
        step();
        step();
        checks++;
        if (bus.o_grant_valid !== 1'b1 || bus.o_grant_idx !== 2'd2 || bus.i_tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got gv=%b gi=%0d busy=%b, expected 1 2 1",
                     bus.o_grant_valid, bus.o_grant_idx, bus.i_tx_busy);
        end
        wait_sent(1, ok);
        checks++;
        if (!ok || sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_sent: got %0d bytes first=%h, expected 1 byte a5", sent_q.size(),
                     (sent_q.size() > 0) ? sent_q[0] : 8'h00);
        end
        // ptr is now 3: requester 3 beats requester 0.
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        en = 4'b1001;
        #1;
        checks++;
        if (bus.o_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL ptr_after_single: got ready=%b, expected 1000", bus.o_req_ready);
        end
        wait_sent(3, ok);
        checks++;
        if (!ok || sent_q.size() != 3 || sent_q[1] !== 8'h03 || sent_q[2] !== 8'h01) begin
            errors++;
            $display("FAIL ptr_order: got %0d bytes, expected 03 then 01", sent_q.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [7:0] exp_b [5];
        exp_b = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        apply_reset();
        push(0, 8'h00, 1'b1);
        push(0, 8'h00, 1'b1);
        push(1, 8'h11, 1'b1);
        push(2, 8'h22, 1'b1);
        push(3, 8'h33, 1'b1);
        en = 4'b1111;
        wait_sent(5, ok);
        checks++;
        if (!ok || sent_q.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d bytes, expected 5", sent_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (sent_q[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL rr_byte%0d: got %h, expected %h", i, sent_q[i], exp_b[i]);
                end
            end
            // Back-to-back spacing: frame plus 3 cycles of overhead.
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (en_cyc_q[i] - en_cyc_q[i-1] != FRAME + 3) begin
                    errors++;
                    $display("FAIL rr_spacing%0d: got %0d cycles, expected %0d", i,
                             en_cyc_q[i] - en_cyc_q[i-1], FRAME + 3);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        bit gap_ready;
        apply_reset();
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        en = 4'b0010;
        wait_count(1, ok);
        push(0, 8'hF0, 1'b1);
        en = 4'b0011;
        wait_sent(4, ok);
        checks++;
        if (!ok || sent_q.size() != 4 || sent_q[0] !== 8'h10 || sent_q[1] !== 8'h11 ||
            sent_q[2] !== 8'h12 || sent_q[3] !== 8'hF0) begin
            errors++;
            $display("FAIL lock_order: got %0d bytes, expected 10 11 12 f0", sent_q.size());
        end
        // Owner goes quiet mid-packet; requester 0 must not slip in.
        push(1, 8'h20, 1'b0);
        push(1, 8'h21, 1'b1);
        wait_count(5, ok);
        en = 4'b0001;
        push(0, 8'hF1, 1'b1);
        gap_ready = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (bus.o_req_ready != 0) gap_ready = 1'b1;
        end
        checks++;
        if (gap_ready || sent_q.size() != 5 || bus.o_grant_valid !== 1'b1 || bus.o_grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL lock_gap: got ready_seen=%b bytes=%0d gv=%b gi=%0d, expected 0 5 1 1",
                     gap_ready, sent_q.size(), bus.o_grant_valid, bus.o_grant_idx);
        end
        en = 4'b0011;
        wait_sent(7, ok);
        checks++;
        if (!ok || sent_q.size() != 7 || sent_q[5] !== 8'h21 || sent_q[6] !== 8'hF1) begin
            errors++;
            $display("FAIL lock_resume: got %0d bytes, expected ... 21 f1", sent_q.size());
        end
    endtask

    task automatic test_timeout();
        int c;
        bit seen;
        apply_reset();
        busy_mode = 1;
        push(0, 8'h55, 1'b0);
        push(0, 8'h56, 1'b1);
        push(1, 8'h66, 1'b1);
        en = 4'b0011;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.o_tx_enable === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || bus.o_tx_data !== 8'h55) begin
            errors++;
            $display("FAIL to_load: got seen=%b data=%h, expected 1 55", seen, bus.o_tx_data);
        end
        c = 0;
        do begin
            step();
            c++;
        end while (bus.o_busy_err !== 1'b1 && c < 40);
        checks++;
        if (c != 16) begin
            errors++;
            $display("FAIL to_delay: got %0d cycles, expected 16", c);
        end
        step();
        checks++;
        if (bus.o_busy_err !== 1'b0 || bus.o_grant_valid !== 1'b0 || bus.o_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL to_release: got err=%b gv=%b ready=%b, expected 0 0 0010",
                     bus.o_busy_err, bus.o_grant_valid, bus.o_req_ready);
        end
        step();
        checks++;
        if (bus.o_tx_enable !== 1'b1 || bus.o_tx_data !== 8'h66) begin
            errors++;
            $display("FAIL to_next: got en=%b data=%h, expected 1 66", bus.o_tx_enable, bus.o_tx_data);
        end
        en = '0;
        repeat (30) step();
        busy_mode = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset();
        busy_mode = 2;
        push(3, 8'h3C, 1'b1);
        en = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.o_req_ready !== 4'b0000 || bus.o_tx_enable !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got ready=%b en=%b, expected 0000 0", i,
                         bus.o_req_ready, bus.o_tx_enable);
            end
        end
        busy_mode = 0;
        #1;
        checks++;
        if (bus.o_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release: got ready=%b, expected 1000", bus.o_req_ready);
        end
        step();
        checks++;
        if (bus.o_tx_enable !== 1'b1 || bus.o_tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL bp_load: got en=%b data=%h, expected 1 3c", bus.o_tx_enable, bus.o_tx_data);
        end
        wait_sent(1, ok);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        apply_reset();
        push(1, 8'h77, 1'b1);
        en = 4'b0010;
        wait_count(1, ok);
        step();
        step();
        push(0, 8'h0A, 1'b1);
        push(2, 8'h2A, 1'b1);
        en = 4'b0111;
        #1;
        checks++;
        if (bus.i_tx_busy !== 1'b1 || bus.o_grant_valid !== 1'b1 || bus.o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_midframe_pre: got busy=%b gv=%b ready=%b, expected 1 1 0000",
                     bus.i_tx_busy, bus.o_grant_valid, bus.o_req_ready);
        end
        i_rst_n = 1'b0;
        step();
        checks++;
        if ({bus.o_req_ready, bus.o_tx_enable, bus.o_tx_data, bus.o_grant_valid,
             bus.o_grant_idx, bus.o_busy_err} !== 17'h0) begin
            errors++;
            $display("FAIL rst_midframe_outputs: got ready=%b en=%b data=%h gv=%b gi=%0d err=%b, expected all 0",
                     bus.o_req_ready, bus.o_tx_enable, bus.o_tx_data, bus.o_grant_valid,
                     bus.o_grant_idx, bus.o_busy_err);
        end
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (bus.o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_midframe_ptr: got ready=%b, expected 0001", bus.o_req_ready);
        end
        wait_sent(3, ok);
        checks++;
        if (!ok || sent_q.size() != 3 || sent_q[1] !== 8'h0A || sent_q[2] !== 8'h2A) begin
            errors++;
            $display("FAIL rst_midframe_order: got %0d bytes, expected 77 0a 2a", sent_q.size());
        end
    endtask

    task automatic test_protocol_monitor();
        checks++;
        if (mon_bad != 0) begin
            errors++;
            $display("FAIL protocol_monitor: got %0d violations, expected 0", mon_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_backpressure();
        test_reset_mid_frame();
        test_protocol_monitor();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `NumReq` byte-stream requesters (e.g. debug console, status reporter, command-response path). It accepts one byte at a time from the winning requester, drives the transmitter's one-cycle `tx_enable`/`tx_data` load, and tracks `tx_busy` to know when the frame is done. Multi-byte packets marked with `last` are kept contiguous on the wire. It sits between the requester logic and `uart_tx`; `uart_rx` is unaffected.

## Interface
- `NumReq`, default 4: number of requesters, from 2 to 8.
- `IdxW`, default 2: width of the grant index; must equal clog2(`NumReq`).
- `BusyTimeout`, default 16: number of cycles allowed for `tx_busy` to rise after a load.
- `i_clk`  in  1  single clock for the whole block.
- `i_rst_n`  in  1  reset, synchronous and active-low.
- `i_req_valid`  in  NumReq  bit k set means requester k offers a byte.
- `i_req_data`  in  8*NumReq  requester k's byte is on bits [8k+7:8k].
- `i_req_last`  in  NumReq  the offered byte from requester k ends its packet.
- `o_req_ready`  out  NumReq  one-hot pulse; the byte is accepted when valid and ready are both high.
- `o_tx_enable`  out  1  one-cycle load strobe to `uart_tx`.
- `o_tx_data`  out  8  byte presented to `uart_tx`; it is held stable until the next accept.
- `i_tx_busy`  in  1  busy flag from `uart_tx`.
- `o_grant_valid`  out  1  a requester currently owns the transmitter.
- `o_grant_idx`  out  IdxW  index of the owning requester.
- `o_busy_err`  out  1  one-cycle pulse when `tx_busy` fails to rise within `BusyTimeout`.

## Operation
- Registers:
  - state: IDLE, LOAD, WAIT_START, WAIT_DONE.
  - `ptr` (IdxW bits): round-robin start point.
  - `lock` (1 bit) and `owner` (IdxW bits).
  - timeout counter: clog2(BusyTimeout)+1 bits.
- IDLE:
  - The eligible set is {`owner`} when `lock`=1; otherwise it is all requesters.
  - The winner is the first requester k with `i_req_valid[k]`=1 in the eligible set, scanning from `ptr` upward with wrap at `NumReq`-1 back to 0.
  - When a winner exists and `i_tx_busy`=0, `o_req_ready[winner]`=1 combinationally. That cycle is the accept:
    - `o_tx_data` <= byte and `owner` <= winner.
    - `lock` <= ~last.
    - If last=1, `ptr` <= winner+1 mod `NumReq`.
    - Next state is LOAD.
  - While locked, if `owner` drops valid, the block waits in IDLE. No other requester is served until `owner` sends a byte with last=1 or a timeout occurs.
  - If `i_tx_busy`=1 in IDLE, no accept happens and all ready bits stay 0.
- LOAD: `o_tx_enable`=1 for exactly this cycle; the counter is cleared; next state is WAIT_START.
- WAIT_START:
  - If `i_tx_busy`=1, go to WAIT_DONE.
  - Otherwise the counter increments. When it reaches `BusyTimeout`:
    - `o_busy_err` pulses.
    - `lock` <= 0 and `ptr` <= owner+1.
    - Next state is IDLE.
- WAIT_DONE: go to IDLE on the first cycle with `i_tx_busy`=0.
- `o_grant_valid` = (state≠IDLE) | `lock`. `o_grant_idx` = `owner`.
- A byte with last=1 from an unlocked requester is a single-byte packet.

## Timing
- Reset (at a clock edge with `i_rst_n`=0):
  - State is IDLE; `ptr`, `lock`, `owner` and the counter are 0.
  - All outputs are 0: `o_req_ready`, `o_tx_enable`, `o_tx_data`, `o_grant_valid`, `o_grant_idx`, `o_busy_err`.
  - Reset while a byte is in progress discards it. No recovery attempt is made; `uart_tx` shares the same reset.
- Accept at cycle T:
  - `o_tx_enable`=1 at T+1.
  - `i_tx_busy` is expected high by T+2, because `uart_tx` raises busy one cycle after enable.
- After `i_tx_busy` falls at cycle D, the earliest next accept is D+1.
- Per-byte overhead beyond the UART frame is 3 cycles.
- Fairness: each requester waits at most `NumReq`-1 packets.
- `o_req_ready` is never asserted outside IDLE and is never multi-hot.

## Test plan
Bench: `uart_tx`/`uart_rx` at 27 MHz / 115200 baud with tx looped to rx, unless a stub is stated.
- Single byte: requester 2 offers 0xA5 with last=1.
  - One ready[2] pulse at T, `o_tx_enable` at T+1 with `o_tx_data`=0xA5.
  - `uart_rx` delivers 0xA5.
  - `o_grant_idx`=2 during the frame; `ptr`=3 afterwards.
- Round robin: all four requesters hold valid, each byte with last=1, data 0x00/0x11/0x22/0x33.
  - Received order is 0x00, 0x11, 0x22, 0x33, 0x00.
- Packet lock:
  - Requester 1 alone offers 0x10, then 0x11, then 0x12 (last=1 on 0x12).
  - Requester 0 raises valid with 0xF0 after the first byte is accepted.
  - Received order is 0x10, 0x11, 0x12, 0xF0.
  - Requester 1 deasserts valid for 5000 cycles mid-packet: no byte from requester 0 goes out in that gap.
- Timeout: stub `i_tx_busy` stuck at 0; requester 0 offers 0x55.
  - `o_busy_err` pulses 16 cycles after `o_tx_enable`.
  - The block returns to IDLE and requester 1 (valid) is served next.
- Busy backpressure: force `i_tx_busy`=1 with requester 3 valid in IDLE.
  - No ready and no enable until busy drops; accept happens on the next cycle.
- Reset mid-frame: drive `i_rst_n`=0 for one cycle during WAIT_DONE.
  - All outputs are 0 after that edge; `ptr`=0.
  - After reset, requester 0 (valid) wins before requester 2 (valid).
